// File: rtl/alu_share_ctrl_if.sv
// Bundle of request, ALU and response signals between the shared-ALU
// controller and its surroundings (requesters, ALU, response consumer).
interface alu_share_ctrl_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [3:0]  req0_op;
  logic [15:0] req0_a;
  logic [15:0] req0_b;

  logic        req1_valid;
  logic        req1_ready;
  logic [3:0]  req1_op;
  logic [15:0] req1_a;
  logic [15:0] req1_b;

  logic [3:0]  alu_opcode;
  logic [15:0] alu_in1;
  logic [15:0] alu_in2;
  logic [15:0] alu_result;
  logic [2:0]  alu_flags;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [15:0] rsp_data;
  logic        rsp_err;

  logic [2:0]  flags;
  logic        busy;

  // Environment side: requesters, the ALU itself and the response consumer.
  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  alu_opcode, alu_in1, alu_in2,
    output alu_result, alu_flags,
    input  rsp_valid, rsp_id, rsp_data, rsp_err,
    output rsp_ready,
    input  flags, busy
  );

  // Controller side.
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output alu_opcode, alu_in1, alu_in2,
    input  alu_result, alu_flags,
    output rsp_valid, rsp_id, rsp_data, rsp_err,
    input  rsp_ready,
    output flags, busy
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// Shares one combinational 16-bit ALU between the execute port (0) and the
// auxiliary/debug port (1). One operation is in flight at a time: accept in
// IDLE, drive the ALU for one EXEC cycle, then hold a tagged response in RESP.
// Also owns the architectural {Z,V,N} flag register.
module alu_share_ctrl #(
  parameter int unsigned RESET_PRIO    = 0,
  parameter int unsigned NUM_OPS_VALID = 10
) (
  input logic             clk,
  input logic             rst_n,
  alu_share_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        prio;
  logic        grant0;
  logic        grant1;
  logic        grant_any;

  logic [3:0]  opcode_q;
  logic [15:0] in1_q;
  logic [15:0] in2_q;

  logic        rsp_valid_q;
  logic        rsp_id_q;
  logic [15:0] rsp_data_q;
  logic        rsp_err_q;
  logic [2:0]  flags_q;

  logic        op_legal;
  logic        upd_all;
  logic        upd_z;

  // Grant: a lone requester wins outright, a tie goes to the port named by prio.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant0 = ~prio;
      grant1 = prio;
    end else begin
      grant0 = bus.req0_valid;
      grant1 = bus.req1_valid;
    end
  end

  assign grant_any = grant0 | grant1;

  // Decode the registered opcode into legality and which flags it may touch.
  always_comb begin
    op_legal = (32'(opcode_q) < NUM_OPS_VALID);
    upd_all  = 1'b0;
    upd_z    = 1'b0;
    if (op_legal) begin
      case (opcode_q)
        4'd0, 4'd1:             upd_all = 1'b1;
        4'd2, 4'd4, 4'd5, 4'd6: upd_z   = 1'b1;
        default: begin
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: EXEC always lasts exactly one cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_any) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, result/flag capture and response bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio        <= 1'(RESET_PRIO);
      opcode_q    <= 4'h0;
      in1_q       <= 16'h0000;
      in2_q       <= 16'h0000;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= 16'h0000;
      rsp_err_q   <= 1'b0;
      flags_q     <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            opcode_q <= grant1 ? bus.req1_op : bus.req0_op;
            in1_q    <= grant1 ? bus.req1_a  : bus.req0_a;
            in2_q    <= grant1 ? bus.req1_b  : bus.req0_b;
            rsp_id_q <= grant1;
            prio     <= ~grant1;
          end
        end
        EXEC: begin
          rsp_valid_q <= 1'b1;
          if (op_legal) begin
            rsp_data_q <= bus.alu_result;
            rsp_err_q  <= 1'b0;
          end else begin
            rsp_data_q <= 16'h0000;
            rsp_err_q  <= 1'b1;
          end
          if (upd_all) begin
            flags_q <= bus.alu_flags;
          end else if (upd_z) begin
            flags_q[2] <= bus.alu_flags[2];
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.req0_ready = (state == IDLE) && grant0;
  assign bus.req1_ready = (state == IDLE) && grant1;
  assign bus.alu_opcode = opcode_q;
  assign bus.alu_in1    = in1_q;
  assign bus.alu_in2    = in2_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.flags      = flags_q;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl. Supplies a behavioural ALU, keeps a
// transaction-level model of arbitration and flag rules, and runs directed
// scenarios followed by randomized traffic.
module tb_alu_share_ctrl;

  localparam int unsigned RESET_PRIO = 0;
  localparam int unsigned NUM_OPS    = 10;

  logic clk;
  logic rst_n;

  int checks;
  int errors;

  bit       m_ptr;
  logic [2:0] m_flags;

  alu_share_ctrl_if bus ();

  alu_share_ctrl #(
    .RESET_PRIO    (RESET_PRIO),
    .NUM_OPS_VALID (NUM_OPS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: returns {Z,V,N,result}. ADD/SUB saturate and set V on
  // overflow; illegal opcodes return deliberately misleading flags.
  function automatic logic [18:0] alu_model(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
    int          sum;
    logic [15:0] r;
    logic        v;
    logic        z;
    logic        n;
    logic [3:0]  sh;
    sh  = b[3:0];
    v   = a[0] ^ b[0] ^ 1'b1;
    sum = 0;
    case (op)
      4'd0, 4'd1: begin
        if (op == 4'd0) sum = int'($signed(a)) + int'($signed(b));
        else            sum = int'($signed(a)) - int'($signed(b));
        if (sum > 32767) begin
          r = 16'h7FFF;
          v = 1'b1;
        end else if (sum < -32768) begin
          r = 16'h8000;
          v = 1'b1;
        end else begin
          r = sum[15:0];
          v = 1'b0;
        end
      end
      4'd2:    r = a ^ b;
      4'd3:    r = a & b;
      4'd4:    r = a << sh;
      4'd5:    r = 16'($signed(a) >>> sh);
      4'd6:    r = (a >> sh) | (a << (5'd16 - {1'b0, sh}));
      4'd7:    r = a | b;
      4'd8:    r = a + b;
      4'd9:    r = b;
      default: r = a ^ b ^ 16'h5A5A;
    endcase
    z = (r == 16'h0000);
    n = r[15];
    if (op >= 4'd10) begin
      z = ~z;
      v = ~v;
      n = ~n;
    end
    return {z, v, n, r};
  endfunction

  assign {bus.alu_flags, bus.alu_result} = alu_model(bus.alu_opcode, bus.alu_in1, bus.alu_in2);

  // Reference: expected response for one completed op, updating the model flags.
  function automatic void model_op(input logic [3:0] op, input logic [15:0] a,
                                   input logic [15:0] b, output logic [15:0] d,
                                   output logic e);
    logic [18:0] res;
    res = alu_model(op, a, b);
    if (32'(op) < NUM_OPS) begin
      d = res[15:0];
      e = 1'b0;
      if (op == 4'd0 || op == 4'd1) m_flags = res[18:16];
      else if (op inside {4'd2, 4'd4, 4'd5, 4'd6}) m_flags[2] = res[18];
    end else begin
      d = 16'h0000;
      e = 1'b1;
    end
  endfunction

  task automatic clear_reqs;
    bus.req0_valid = 1'b0;
    bus.req0_op    = 4'h0;
    bus.req0_a     = 16'h0000;
    bus.req0_b     = 16'h0000;
    bus.req1_valid = 1'b0;
    bus.req1_op    = 4'h0;
    bus.req1_a     = 16'h0000;
    bus.req1_b     = 16'h0000;
  endtask

  // Two-cycle reset; leaves the bench one step after a rising edge.
  task automatic do_reset;
    clear_reqs();
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    m_ptr   = 1'(RESET_PRIO);
    m_flags = 3'b000;
  endtask

  // Issue one single-port request; returns at a falling edge with the response up.
  task automatic send(input bit port, input logic [3:0] op, input logic [15:0] a,
                      input logic [15:0] b, output bit ok);
    int n;
    ok = 1'b1;
    if (port) begin
      bus.req1_valid = 1'b1;
      bus.req1_op    = op;
      bus.req1_a     = a;
      bus.req1_b     = b;
    end else begin
      bus.req0_valid = 1'b1;
      bus.req0_op    = op;
      bus.req0_a     = a;
      bus.req0_b     = b;
    end
    @(negedge clk);
    n = 0;
    while (!(port ? bus.req1_ready : bus.req0_ready) && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!(port ? bus.req1_ready : bus.req0_ready)) ok = 1'b0;
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    m_ptr = ~port;
    @(negedge clk);
    n = 0;
    while (!bus.rsp_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rsp_valid) ok = 1'b0;
  endtask

  // Accept the response after holding rsp_ready low for some cycles.
  task automatic ack(input int hold);
    repeat (hold) @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    @(negedge clk);
    checks++; if (bus.flags !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000", bus.flags); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin errors++; $display("[TB] FAIL reset_readys: got %b expected 00", {bus.req1_ready, bus.req0_ready}); end
    checks++; if ({bus.rsp_id, bus.rsp_err, bus.rsp_data} !== 18'h0) begin errors++; $display("[TB] FAIL reset_rsp_fields: got %h expected 0", {bus.rsp_id, bus.rsp_err, bus.rsp_data}); end
    checks++; if ({bus.alu_opcode, bus.alu_in1, bus.alu_in2} !== 36'h0) begin errors++; $display("[TB] FAIL reset_alu_regs: got %h expected 0", {bus.alu_opcode, bus.alu_in1, bus.alu_in2}); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_add;
    logic [15:0] ed;
    logic        ee;
    bus.req0_valid = 1'b1;
    bus.req0_op    = 4'd0;
    bus.req0_a     = 16'h7FFF;
    bus.req0_b     = 16'h0001;
    @(negedge clk);
    checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin errors++; $display("[TB] FAIL add_grant: got %b expected 01", {bus.req1_ready, bus.req0_ready}); end
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    m_ptr = 1'b1;
    model_op(4'd0, 16'h7FFF, 16'h0001, ed, ee);
    @(negedge clk);
    checks++; if ({bus.rsp_valid, bus.busy} !== 2'b01) begin errors++; $display("[TB] FAIL add_exec_state: got %b expected 01", {bus.rsp_valid, bus.busy}); end
    checks++; if ({bus.alu_opcode, bus.alu_in1, bus.alu_in2} !== {4'd0, 16'h7FFF, 16'h0001}) begin errors++; $display("[TB] FAIL add_alu_drive: got %h expected 07fff0001", {bus.alu_opcode, bus.alu_in1, bus.alu_in2}); end
    checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin errors++; $display("[TB] FAIL add_exec_readys: got %b expected 00", {bus.req1_ready, bus.req0_ready}); end
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL add_latency: got %b expected 1", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 16'h7FFF) begin errors++; $display("[TB] FAIL add_data: got %h expected 7fff", bus.rsp_data); end
    checks++; if ({bus.rsp_id, bus.rsp_err} !== 2'b00) begin errors++; $display("[TB] FAIL add_id_err: got %b expected 00", {bus.rsp_id, bus.rsp_err}); end
    checks++; if (bus.flags !== 3'b010) begin errors++; $display("[TB] FAIL add_flags: got %b expected 010", bus.flags); end
    ack(0);
  endtask

  task automatic test_flag_update;
    bit          ok;
    logic [15:0] ed;
    logic        ee;
    send(0, 4'd1, 16'h0005, 16'h0005, ok);
    model_op(4'd1, 16'h0005, 16'h0005, ed, ee);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL sub_timeout: got no response expected one"); end
    checks++; if ({bus.rsp_data, bus.flags} !== {16'h0000, 3'b100}) begin errors++; $display("[TB] FAIL sub_zero: got %h/%b expected 0000/100", bus.rsp_data, bus.flags); end
    ack(0);
    send(1, 4'd2, 16'h00F0, 16'h000F, ok);
    model_op(4'd2, 16'h00F0, 16'h000F, ed, ee);
    checks++; if ({bus.rsp_data, bus.flags} !== {16'h00FF, 3'b000}) begin errors++; $display("[TB] FAIL xor_flags: got %h/%b expected 00ff/000", bus.rsp_data, bus.flags); end
    ack(1);
    send(0, 4'd0, 16'h8000, 16'hFFFF, ok);
    model_op(4'd0, 16'h8000, 16'hFFFF, ed, ee);
    checks++; if ({bus.rsp_data, bus.flags} !== {16'h8000, 3'b011}) begin errors++; $display("[TB] FAIL add_neg_ovf: got %h/%b expected 8000/011", bus.rsp_data, bus.flags); end
    ack(0);
    send(1, 4'd4, 16'h0000, 16'h0003, ok);
    model_op(4'd4, 16'h0000, 16'h0003, ed, ee);
    checks++; if ({bus.rsp_data, bus.flags} !== {16'h0000, 3'b111}) begin errors++; $display("[TB] FAIL sll_z_only: got %h/%b expected 0000/111", bus.rsp_data, bus.flags); end
    ack(0);
  endtask

  task automatic test_contention;
    logic [15:0] ed;
    logic        ee;
    bit          exp_port;
    int          n;
    do_reset();
    bus.rsp_ready  = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_op    = 4'd0;
    bus.req0_a     = 16'h1234;
    bus.req0_b     = 16'h0100;
    bus.req1_valid = 1'b1;
    bus.req1_op    = 4'd2;
    bus.req1_a     = 16'hFF00;
    bus.req1_b     = 16'h0F0F;
    for (int i = 0; i < 4; i++) begin
      exp_port = (i % 2 == 1);
      @(negedge clk);
      checks++; if ({bus.req1_ready, bus.req0_ready} !== (exp_port ? 2'b10 : 2'b01)) begin errors++; $display("[TB] FAIL contention_grant[%0d]: got %b expected %b", i, {bus.req1_ready, bus.req0_ready}, exp_port ? 2'b10 : 2'b01); end
      if (exp_port) model_op(4'd2, 16'hFF00, 16'h0F0F, ed, ee);
      else          model_op(4'd0, 16'h1234, 16'h0100, ed, ee);
      m_ptr = ~exp_port;
      @(posedge clk);
      #1;
      @(negedge clk);
      n = 0;
      while (!bus.rsp_valid && n < 8) begin
        @(negedge clk);
        n++;
      end
      checks++; if ({bus.rsp_valid, bus.rsp_id} !== {1'b1, exp_port}) begin errors++; $display("[TB] FAIL contention_id[%0d]: got %b expected %b", i, {bus.rsp_valid, bus.rsp_id}, {1'b1, exp_port}); end
      checks++; if (bus.rsp_data !== ed) begin errors++; $display("[TB] FAIL contention_data[%0d]: got %h expected %h", i, bus.rsp_data, ed); end
      @(posedge clk);
      #1;
    end
    clear_reqs();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    bit          ok;
    logic [15:0] ed;
    logic [15:0] ed0;
    logic        ee;
    int          n;
    send(1, 4'd3, 16'hF0F0, 16'h3C3C, ok);
    model_op(4'd3, 16'hF0F0, 16'h3C3C, ed, ee);
    bus.req0_valid = 1'b1;
    bus.req0_op    = 4'd1;
    bus.req0_a     = 16'h0010;
    bus.req0_b     = 16'h0020;
    for (int i = 0; i < 5; i++) begin
      checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b1, 1'b1, ed}) begin errors++; $display("[TB] FAIL bp_stable[%0d]: got %h expected %h", i, {bus.rsp_valid, bus.rsp_id, bus.rsp_data}, {1'b1, 1'b1, ed}); end
      checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin errors++; $display("[TB] FAIL bp_readys[%0d]: got %b expected 00", i, {bus.req1_ready, bus.req0_ready}); end
      @(negedge clk);
    end
    ack(0);
    @(negedge clk);
    checks++; if ({bus.busy, bus.req0_ready} !== 2'b01) begin errors++; $display("[TB] FAIL bp_next_grant: got %b expected 01", {bus.busy, bus.req0_ready}); end
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    m_ptr = 1'b1;
    model_op(4'd1, 16'h0010, 16'h0020, ed0, ee);
    @(negedge clk);
    n = 0;
    while (!bus.rsp_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    checks++; if ({bus.rsp_valid, bus.rsp_data, bus.flags} !== {1'b1, ed0, m_flags}) begin errors++; $display("[TB] FAIL bp_second_op: got %h expected %h", {bus.rsp_valid, bus.rsp_data, bus.flags}, {1'b1, ed0, m_flags}); end
    ack(2);
  endtask

  task automatic test_illegal_op;
    bit          ok;
    logic [15:0] ed;
    logic        ee;
    send(0, 4'b1100, 16'h1111, 16'h2222, ok);
    model_op(4'b1100, 16'h1111, 16'h2222, ed, ee);
    checks++; if ({bus.rsp_err, bus.rsp_data} !== {1'b1, 16'h0000}) begin errors++; $display("[TB] FAIL illegal_err_data: got %h expected 10000", {bus.rsp_err, bus.rsp_data}); end
    checks++; if (bus.flags !== m_flags) begin errors++; $display("[TB] FAIL illegal_flags_hold: got %b expected %b", bus.flags, m_flags); end
    ack(0);
    @(negedge clk);
    checks++; if ({bus.rsp_valid, bus.rsp_err} !== 2'b00) begin errors++; $display("[TB] FAIL illegal_err_clear: got %b expected 00", {bus.rsp_valid, bus.rsp_err}); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_op;
    bit          ok;
    logic [15:0] ed;
    logic        ee;
    send(0, 4'd0, 16'h8000, 16'hFFFF, ok);
    model_op(4'd0, 16'h8000, 16'hFFFF, ed, ee);
    ack(0);
    checks++; if (bus.flags !== 3'b011) begin errors++; $display("[TB] FAIL midreset_pre_flags: got %b expected 011", bus.flags); end
    bus.req0_valid = 1'b1;
    bus.req0_op    = 4'd0;
    bus.req0_a     = 16'h7FFF;
    bus.req0_b     = 16'h0001;
    @(negedge clk);
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL midreset_in_exec: got %b expected 1", bus.busy); end
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    m_ptr   = 1'(RESET_PRIO);
    m_flags = 3'b000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if ({bus.rsp_valid, bus.busy, bus.flags} !== 5'b00000) begin errors++; $display("[TB] FAIL midreset_abort[%0d]: got %b expected 00000", i, {bus.rsp_valid, bus.busy, bus.flags}); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random;
    bit          v0;
    bit          v1;
    bit          gp;
    logic [3:0]  o0;
    logic [3:0]  o1;
    logic [15:0] a0;
    logic [15:0] b0;
    logic [15:0] a1;
    logic [15:0] b1;
    logic [15:0] ed;
    logic        ee;
    int          n;
    for (int i = 0; i < 40; i++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      o0 = 4'($urandom_range(0, 15));
      o1 = 4'($urandom_range(0, 15));
      a0 = 16'($urandom);
      b0 = ($urandom_range(0, 3) == 0) ? a0 : 16'($urandom);
      a1 = 16'($urandom);
      b1 = ($urandom_range(0, 3) == 0) ? a1 : 16'($urandom);
      gp = (v0 && v1) ? m_ptr : v1;
      bus.req0_valid = v0;
      bus.req0_op    = o0;
      bus.req0_a     = a0;
      bus.req0_b     = b0;
      bus.req1_valid = v1;
      bus.req1_op    = o1;
      bus.req1_a     = a1;
      bus.req1_b     = b1;
      @(negedge clk);
      checks++; if ({bus.req1_ready, bus.req0_ready} !== (gp ? 2'b10 : 2'b01)) begin errors++; $display("[TB] FAIL rand_grant[%0d]: got %b expected %b", i, {bus.req1_ready, bus.req0_ready}, gp ? 2'b10 : 2'b01); end
      @(posedge clk);
      #1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      m_ptr = ~gp;
      if (gp) model_op(o1, a1, b1, ed, ee);
      else    model_op(o0, a0, b0, ed, ee);
      @(negedge clk);
      n = 0;
      while (!bus.rsp_valid && n < 8) begin
        @(negedge clk);
        n++;
      end
      checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_err} !== {1'b1, gp, ee}) begin errors++; $display("[TB] FAIL rand_rsp_tag[%0d]: got %b expected %b", i, {bus.rsp_valid, bus.rsp_id, bus.rsp_err}, {1'b1, gp, ee}); end
      checks++; if (bus.rsp_data !== ed) begin errors++; $display("[TB] FAIL rand_data[%0d]: got %h expected %h", i, bus.rsp_data, ed); end
      checks++; if (bus.flags !== m_flags) begin errors++; $display("[TB] FAIL rand_flags[%0d]: got %b expected %b", i, bus.flags, m_flags); end
      ack($urandom_range(0, 2));
    end
  endtask

  // Safety net so the run always ends even if the design wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence.
  initial begin
    checks  = 0;
    errors  = 0;
    m_ptr   = 1'(RESET_PRIO);
    m_flags = 3'b000;
    rst_n   = 1'b0;
    bus.rsp_ready = 1'b0;
    clear_reqs();
    test_reset();
    test_single_add();
    test_flag_update();
    test_contention();
    test_backpressure();
    test_illegal_op();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Arbitration and sequencing controller that shares the single combinational 16-bit ALU between two requesters: the execute-stage port (port 0) and the auxiliary or debug port (port 1).
- Accepts one operation at a time under a valid/ready handshake, registers the operands and drives the ALU.
- Captures the result and the Z/V/N flags, then returns a tagged response under a valid/ready handshake.
- Owns the architectural flag register and applies the per-opcode flag-update rules.

Parameters:
- RESET_PRIO, 0: port that holds priority after reset (0 or 1).
- NUM_OPS_VALID, 10: opcodes below this value are legal; opcodes at or above it are rejected as errors.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- req0_valid / req1_valid  input  1  request present on port 0 / port 1.
- req0_ready / req1_ready  output  1  request accepted this cycle.
- req0_op / req1_op  input  4  ALU opcode.
- req0_a / req1_a  input  16  operand 1.
- req0_b / req1_b  input  16  operand 2.
- alu_opcode  output  4  opcode to the ALU.
- alu_in1  output  16  operand 1 to the ALU.
- alu_in2  output  16  operand 2 to the ALU.
- alu_result  input  16  ALU output.
- alu_flags  input  3  ALU flags as {Z,V,N}.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  1  port that issued the request.
- rsp_data  output  16  captured result.
- rsp_err  output  1  illegal opcode.
- flags  output  3  architectural flag register {Z,V,N}.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset (rst_n low at a clock edge):
  - state returns to IDLE and the priority pointer is set to RESET_PRIO.
  - flags = 3'b000, rsp_valid = 0, rsp_id = 0, rsp_data = 16'h0000, rsp_err = 0.
  - alu_opcode, alu_in1 and alu_in2 registers are cleared to 0.
  - Reset applied mid-operation aborts the operation: no response is produced and the flags are not updated.
- The state machine has three states: IDLE, EXEC and RESP.
- IDLE:
  - Grant logic is combinational from req0_valid, req1_valid and the pointer.
  - If only one port is valid, that port is granted.
  - If both ports are valid, the port named by the pointer is granted.
  - reqN_ready = (state==IDLE) & grantN. At most one ready is high in any cycle. Both readys are 0 outside IDLE.
  - On handshake: latch op, a and b into the ALU drive registers, latch rsp_id = N, set pointer = ~N, and move to EXEC.
  - With no request, the block stays in IDLE and the pointer is unchanged.
- EXEC (exactly one cycle):
  - The ALU inputs are stable from the registers.
  - At the clock edge: rsp_data <= alu_result, rsp_valid <= 1, then move to RESP.
  - If op >= NUM_OPS_VALID: rsp_err <= 1 and rsp_data <= 0.
  - Flag update occurs at the same edge:
    - op 0000 or 0001 (ADD/SUB): flags <= alu_flags (Z, V and N all updated).
    - op 0010, 0100, 0101 or 0110 (XOR/SLL/SRA/ROR): only Z <= alu_flags[2]; V and N hold.
    - All other ops, including illegal ones: flags hold. X values from the ALU must never reach the flags.
- RESP:
  - rsp_valid, rsp_id, rsp_data and rsp_err stay stable until rsp_ready is high.
  - On handshake: rsp_valid <= 0, rsp_err <= 0, then move to IDLE. A new request can be accepted on the following cycle at the earliest.
  - rsp_ready being high in the same cycle that rsp_valid rises has no effect, because the handshake requires rsp_valid to already be 1.
- Timing:
  - Latency is 2 cycles from the request handshake edge to rsp_valid.
  - Minimum issue interval is 3 cycles.
- Fairness: a continuously requesting port waits at most one operation.
- A requester may drop valid before it is granted; no request state is held for it.
- busy = (state != IDLE).
- The flags output is the register output, which reflects the result of the last completed flag-setting operation.

Test Plan:
- Reset then idle: rst_n low for 2 cycles -> flags=000, rsp_valid=0, busy=0, req0_ready=req1_ready=0 while no valid is asserted.
- Single ADD on port 0: op=0000, a=16'h7FFF, b=16'h0001, ALU model saturates -> rsp_valid 2 cycles later, rsp_data=16'h7FFF, rsp_id=0, flags={0,1,0}.
- Selective flag update: SUB 5-5 (flags 100), then XOR 16'h00F0^16'h000F -> rsp_data=16'h00FF, flags=000. Then ADD 16'h8000+16'hFFFF giving N=1, V=1 -> then SLL 16'h0000 by 3 -> flags={1,V,N held}=111.
- Contention: both ports valid continuously for 4 ops starting from RESET_PRIO=0 -> grant order 0,1,0,1, and the rsp_id sequence matches.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_data and rsp_id stay stable, both readys stay 0; release -> IDLE, next grant one cycle later.
- Illegal op and reset mid-op: op=4'b1100 -> rsp_err=1, rsp_data=0, flags unchanged. Separately, assert rst_n=0 during EXEC -> no rsp_valid and flags=000.
